// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared constants for the CPU inter-stage pipeline registers
package cpu_pipe_pkg;

  // Default payload width of one inter-stage register.
  localparam int unsigned DATA_W_DEF = 32;

  // Field placement inside a packed MEM/WB payload (LSB offsets and widths).
  localparam int unsigned MEMWB_ALU_LSB      = 0;
  localparam int unsigned MEMWB_ALU_W        = 32;
  localparam int unsigned MEMWB_DM_LSB       = MEMWB_ALU_LSB + MEMWB_ALU_W;
  localparam int unsigned MEMWB_DM_W         = 32;
  localparam int unsigned MEMWB_RT_LSB       = MEMWB_DM_LSB + MEMWB_DM_W;
  localparam int unsigned MEMWB_RT_W         = 5;
  localparam int unsigned MEMWB_RD_LSB       = MEMWB_RT_LSB + MEMWB_RT_W;
  localparam int unsigned MEMWB_RD_W         = 5;
  localparam int unsigned MEMWB_REGDST_LSB   = MEMWB_RD_LSB + MEMWB_RD_W;
  localparam int unsigned MEMWB_REGSRC_LSB   = MEMWB_REGDST_LSB + 1;
  localparam int unsigned MEMWB_REGWRITE_LSB = MEMWB_REGSRC_LSB + 1;
  localparam int unsigned MEMWB_W            = MEMWB_REGWRITE_LSB + 1;

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one elastic pipeline stage: valid bit plus payload register
module pipe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              adv_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next state: flush kills the beat; otherwise advance takes the upstream
  // valid, and the payload only moves when a real beat moves in.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (adv_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - elastic valid/ready register chain with bubble collapse and flush
module pipe_reg_chain
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0]             valid;
  logic [DEPTH-1:0]             adv;
  logic [DEPTH-1:0][DATA_W-1:0] data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    // A stage may advance when the output drains or any stage from here to
    // the output is empty, so bubbles are squeezed out behind a stall.
    assign adv[k] = out_ready | ~(&valid[DEPTH-1:k]);

    if (k == 0) begin : g_head
      pipe_stage #(.DATA_W(DATA_W)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .adv_i   (adv[k]),
        .valid_i (in_valid),
        .data_i  (in_data),
        .valid_o (valid[k]),
        .data_o  (data[k])
      );
    end else begin : g_body
      pipe_stage #(.DATA_W(DATA_W)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .adv_i   (adv[k]),
        .valid_i (valid[k-1]),
        .data_i  (data[k-1]),
        .valid_o (valid[k]),
        .data_o  (data[k])
      );
    end
  end

  // Occupancy is the popcount of the registered valid bits.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + CNT_W'(valid[k]);
    end
  end

  assign in_ready    = adv[0];
  assign out_valid   = valid[DEPTH-1];
  assign out_data    = data[DEPTH-1];
  assign stage_valid = valid;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - self-checking bench for pipe_reg_chain at depths 3, 2 and 1
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic        d3_in_valid = 0, d3_in_ready, d3_out_valid, d3_out_ready = 0, d3_flush = 0;
  logic [31:0] d3_in_data = 0, d3_out_data;
  logic [2:0]  d3_stage_valid;
  logic [1:0]  d3_occ;

  logic        d2_in_valid = 0, d2_in_ready, d2_out_valid, d2_out_ready = 0, d2_flush = 0;
  logic [31:0] d2_in_data = 0, d2_out_data;
  logic [1:0]  d2_stage_valid;
  logic [1:0]  d2_occ;

  logic        d1_in_valid = 0, d1_in_ready, d1_out_valid, d1_out_ready = 0, d1_flush = 0;
  logic [31:0] d1_in_data = 0, d1_out_data;
  logic [0:0]  d1_stage_valid;
  logic [0:0]  d1_occ;

  pipe_reg_chain #(.DATA_W(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_data(d3_in_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_data(d3_out_data), .flush(d3_flush), .stage_valid(d3_stage_valid),
    .occupancy(d3_occ)
  );

  pipe_reg_chain #(.DATA_W(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_data(d2_in_data), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .out_data(d2_out_data), .flush(d2_flush), .stage_valid(d2_stage_valid),
    .occupancy(d2_occ)
  );

  pipe_reg_chain #(.DATA_W(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_data(d1_in_data), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out_data(d1_out_data), .flush(d1_flush), .stage_valid(d1_stage_valid),
    .occupancy(d1_occ)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all;
    d3_in_valid = 0; d3_out_ready = 0; d3_flush = 0;
    d2_in_valid = 0; d2_out_ready = 0; d2_flush = 0;
    d1_in_valid = 0; d1_out_ready = 0; d1_flush = 0;
    rst_n = 0;
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (d3_out_valid !== 1'b0) begin errors++; $display("FAIL por_out_valid got %0h exp 0", d3_out_valid); end
    checks++; if (d3_in_ready !== 1'b1) begin errors++; $display("FAIL por_in_ready got %0h exp 1", d3_in_ready); end
    checks++; if (d3_out_data !== 32'h0) begin errors++; $display("FAIL por_out_data got %0h exp 0", d3_out_data); end
    rst_n = 1;
    tick;
    d3_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      d3_in_valid = 1; d3_in_data = 32'h50 + i;
      tick;
    end
    d3_in_valid = 0;
    checks++; if (d3_occ !== 2'd3) begin errors++; $display("FAIL midrst_fill got %0d exp 3", d3_occ); end
    rst_n = 0;
    #1;
    checks++; if (d3_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %0h exp 0", d3_out_valid); end
    checks++; if (d3_occ !== 2'd0) begin errors++; $display("FAIL midrst_occ got %0d exp 0", d3_occ); end
    checks++; if (d3_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %0h exp 1", d3_in_ready); end
    checks++; if (d3_out_data !== 32'h0) begin errors++; $display("FAIL midrst_out_data got %0h exp 0", d3_out_data); end
    checks++; if (d3_stage_valid !== 3'b000) begin errors++; $display("FAIL midrst_stage_valid got %0b exp 000", d3_stage_valid); end
    #1;
    rst_n = 1;
    tick;
    checks++; if (d3_occ !== 2'd0) begin errors++; $display("FAIL postrst_occ got %0d exp 0", d3_occ); end
  endtask

  task automatic test_streaming;
    logic [31:0] beats [3];
    beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33;
    clear_all;
    d3_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      d3_in_valid = 1; d3_in_data = beats[i];
      tick;
      if (i < 2) begin
        checks++; if (d3_out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency cycle %0d got %0h exp 0", i, d3_out_valid); end
      end
    end
    d3_in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick;
      checks++; if (d3_out_valid !== 1'b1 || d3_out_data !== beats[i]) begin
        errors++; $display("FAIL stream_beat %0d got v=%0h d=%0h exp v=1 d=%0h", i, d3_out_valid, d3_out_data, beats[i]);
      end
    end
    tick;
    checks++; if (d3_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0h exp 0", d3_out_valid); end
  endtask

  task automatic test_backpressure;
    clear_all;
    d3_out_ready = 0;
    d3_in_valid = 1; d3_in_data = 32'hA; tick;
    d3_in_valid = 0; tick;
    d3_in_valid = 1; d3_in_data = 32'hB; tick;
    d3_in_valid = 1; d3_in_data = 32'hC; tick;
    d3_in_valid = 0;
    checks++; if (d3_occ !== 2'd3) begin errors++; $display("FAIL bp_occ got %0d exp 3", d3_occ); end
    checks++; if (d3_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0h exp 0", d3_in_ready); end
    tick;
    checks++; if (d3_out_valid !== 1'b1 || d3_out_data !== 32'hA) begin
      errors++; $display("FAIL bp_stall_hold got v=%0h d=%0h exp v=1 d=a", d3_out_valid, d3_out_data);
    end
    d3_out_ready = 1;
    #1;
    checks++; if (d3_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got %0h exp 1", d3_in_ready); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick;
      checks++; if (d3_out_valid !== 1'b1 || d3_out_data !== 32'hA + i) begin
        errors++; $display("FAIL bp_order %0d got v=%0h d=%0h exp v=1 d=%0h", i, d3_out_valid, d3_out_data, 32'hA + i);
      end
    end
    tick;
    checks++; if (d3_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0h exp 0", d3_out_valid); end
  endtask

  task automatic test_full_simul;
    clear_all;
    d3_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      d3_in_valid = 1; d3_in_data = 32'hA + i; tick;
    end
    d3_out_ready = 1; d3_in_valid = 1; d3_in_data = 32'hD;
    #1;
    checks++; if (d3_in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready got %0h exp 1", d3_in_ready); end
    tick;
    d3_in_valid = 0;
    checks++; if (d3_occ !== 2'd3) begin errors++; $display("FAIL full_occ got %0d exp 3", d3_occ); end
    tick; tick;
    checks++; if (d3_out_valid !== 1'b1 || d3_out_data !== 32'hD) begin
      errors++; $display("FAIL full_d_out got v=%0h d=%0h exp v=1 d=d", d3_out_valid, d3_out_data);
    end
  endtask

  task automatic test_flush;
    clear_all;
    d2_out_ready = 0;
    d2_in_valid = 1; d2_in_data = 32'h1; tick;
    d2_in_valid = 1; d2_in_data = 32'h2; tick;
    checks++; if (d2_occ !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d exp 2", d2_occ); end
    d2_out_ready = 1; d2_flush = 1; d2_in_valid = 1; d2_in_data = 32'hEE;
    #1;
    checks++; if (d2_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0h exp 1", d2_in_ready); end
    tick;
    d2_flush = 0; d2_in_valid = 0;
    checks++; if (d2_stage_valid !== 2'b00) begin errors++; $display("FAIL flush_stage_valid got %0b exp 00", d2_stage_valid); end
    checks++; if (d2_occ !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", d2_occ); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (d2_out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cycle %0d got v=%0h d=%0h exp v=0", i, d2_out_valid, d2_out_data); end
    end
  endtask

  task automatic test_depth1;
    clear_all;
    d1_out_ready = 0; d1_in_valid = 1; d1_in_data = 32'hAB;
    tick;
    checks++; if (d1_out_valid !== 1'b1 || d1_out_data !== 32'hAB) begin
      errors++; $display("FAIL d1_first got v=%0h d=%0h exp v=1 d=ab", d1_out_valid, d1_out_data);
    end
    checks++; if (d1_in_ready !== 1'b0) begin errors++; $display("FAIL d1_stall_ready got %0h exp 0", d1_in_ready); end
    d1_in_data = 32'hCD; d1_out_ready = 1;
    #1;
    checks++; if (d1_in_ready !== 1'b1) begin errors++; $display("FAIL d1_release_ready got %0h exp 1", d1_in_ready); end
    tick;
    d1_in_valid = 0;
    checks++; if (d1_out_valid !== 1'b1 || d1_out_data !== 32'hCD) begin
      errors++; $display("FAIL d1_back_to_back got v=%0h d=%0h exp v=1 d=cd", d1_out_valid, d1_out_data);
    end
    tick;
    checks++; if (d1_out_valid !== 1'b0 || d1_occ !== 1'b0) begin
      errors++; $display("FAIL d1_drain got v=%0h occ=%0d exp 0", d1_out_valid, d1_occ);
    end
  endtask

  // Reference: three slots; a beat steps forward whenever the output drains
  // or some slot at or ahead of it is empty. Scoreboard tracks delivery order.
  task automatic test_random;
    bit          mv [3];
    bit          nv [3];
    bit          moves [3];
    logic [31:0] md [3];
    logic [31:0] nd [3];
    logic [31:0] sb [$];
    logic [31:0] exp_data;
    int          cnt;
    int          holes;
    bit          exp_ready;
    clear_all;
    for (int k = 0; k < 3; k++) begin mv[k] = 0; md[k] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      d3_in_valid  = ($urandom_range(0, 3) != 0);
      d3_in_data   = $urandom;
      d3_out_ready = ($urandom_range(0, 99) < (((cyc / 40) % 2 == 0) ? 30 : 85));
      d3_flush     = ($urandom_range(0, 24) == 0);
      #1;
      cnt = 0;
      for (int k = 0; k < 3; k++) cnt += int'(mv[k]);
      exp_ready = d3_out_ready || (cnt < 3);
      checks++; if (d3_in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %0h exp %0h", cyc, d3_in_ready, exp_ready); end
      checks++; if (d3_out_valid !== mv[2]) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %0h exp %0h", cyc, d3_out_valid, mv[2]); end
      checks++; if (d3_stage_valid !== {mv[2], mv[1], mv[0]}) begin
        errors++; $display("FAIL rnd_stage_valid cyc %0d got %0b exp %0b", cyc, d3_stage_valid, {mv[2], mv[1], mv[0]});
      end
      checks++; if (int'(d3_occ) !== cnt) begin errors++; $display("FAIL rnd_occ cyc %0d got %0d exp %0d", cyc, d3_occ, cnt); end
      if (mv[2]) begin
        checks++; if (d3_out_data !== md[2]) begin errors++; $display("FAIL rnd_out_data cyc %0d got %0h exp %0h", cyc, d3_out_data, md[2]); end
      end
      if (mv[2] && d3_out_ready) begin
        exp_data = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_0000;
        checks++; if (d3_out_data !== exp_data) begin errors++; $display("FAIL rnd_order cyc %0d got %0h exp %0h", cyc, d3_out_data, exp_data); end
      end
      for (int k = 0; k < 3; k++) begin
        holes = 0;
        for (int j = k; j < 3; j++) holes += int'(!mv[j]);
        moves[k] = d3_out_ready || (holes > 0);
        nv[k] = mv[k];
        nd[k] = md[k];
      end
      if (d3_flush) begin
        for (int k = 0; k < 3; k++) nv[k] = 0;
        sb.delete();
      end else begin
        for (int k = 1; k < 3; k++) begin
          if (moves[k]) begin
            nv[k] = mv[k-1];
            if (mv[k-1]) nd[k] = md[k-1];
          end
        end
        if (moves[0]) begin
          nv[0] = d3_in_valid;
          if (d3_in_valid) begin
            nd[0] = d3_in_data;
            sb.push_back(d3_in_data);
          end
        end
      end
      tick;
      for (int k = 0; k < 3; k++) begin mv[k] = nv[k]; md[k] = nd[k]; end
    end
    d3_in_valid = 0; d3_flush = 0; d3_out_ready = 0;
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_backpressure;
    test_full_simul;
    test_flush;
    test_depth1;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised elastic pipeline register chain replacing the fixed, always-advancing inter-stage registers (IF/ID … MEM/WB). Carries a DATA_W-bit payload through DEPTH register stages with per-stage valid bits, a valid/ready handshake, bubble collapsing and synchronous flush. Sits between any two pipeline stages of the CPU; the writeback side reads `out_data` and hazard logic reads `stage_valid`.

## Interface
Parameters:
- DATA_W, 32, payload width in bits (≥1); packed control and data fields, e.g. aluResult, dmOut, RegSrc, rt, rd, RegDst, RegWrite.
- DEPTH, 1, number of register stages (≥1; DEPTH=0 is illegal).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  upstream has a beat on in_data.
- in_ready  out  1  chain accepts the beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  last stage holds a valid beat.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_data  out  DATA_W  last-stage payload.
- flush  in  1  synchronous kill of every stage.
- stage_valid  out  DEPTH  valid bit per stage; bit 0 = input stage, bit DEPTH-1 = output stage.
- occupancy  out  CNT_W  number of set stage_valid bits.

## Operation
- Stage k holds valid_k, data_k. Stage DEPTH-1 drives out_valid/out_data.
- Advance rule: adv_{DEPTH-1} = out_ready | ~valid_{DEPTH-1}; adv_k = adv_{k+1} | ~valid_k. in_ready = adv_0. The chain is combinational from out_ready to in_ready.
- On a clock edge with adv_k=1, stage k loads from stage k-1 (stage 0 loads in_data/in_valid). With adv_k=0 it holds both valid and data.
- Bubble collapse: an empty stage always accepts, so a downstream stall fills bubbles behind it without blocking.
- Data registers load only when the incoming valid is 1. A bubble moving into a stage clears only valid_k. Data is don't-care when invalid and is never observed.
- Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- flush=1: all valid_k ← 0 at the edge. A same-cycle input beat is discarded even if in_ready=1. A same-cycle output transfer still counts as delivered. Flush takes priority over every advance.
- occupancy = popcount(stage_valid), registered together with the valid bits. It is not a separate counter.
- Reset (rst_n=0, asynchronous): all valid_k=0, all data_k=0. Hence out_valid=0, out_data=0, stage_valid=0, occupancy=0, in_ready=1. Asserting reset mid-stream drops all beats immediately. Release is synchronous to the next edge.

## Timing
- Latency: a beat accepted at edge t appears on out_valid/out_data after edge t+DEPTH-1. For DEPTH=1 it is visible right after the accepting edge.
- Throughput: one beat per cycle while out_ready=1.
- Full chain (all valid) with out_ready=0: in_ready=0 in the same cycle. When out_ready rises, in_ready=1 in that same cycle, with no bubble inserted.
- Full chain with out_ready=1 and in_valid=1: simultaneous in and out transfer; occupancy is unchanged.
- Handshake rules: out_data and out_valid stay stable while out_valid=1 and out_ready=0. in_valid/in_data are sampled only at the edge where in_ready=1.

## Structure
- Shared package `cpu_pipe_pkg`: default DATA_W (32) and field-offset localparams for the MEM/WB payload packing. No typedefs are required.
- Natural sub-module `pipe_stage`: a single valid/data register with an advance input. It is instantiated DEPTH times through a generate loop, and the ready chain is built in the parent.

## Test plan
- Reset: drive rst_n=0 mid-stream with DEPTH=3 and 3 beats held → out_valid=0, occupancy=0, in_ready=1, out_data=0 immediately, without waiting for a clock edge.
- Streaming: DEPTH=3, out_ready=1, beats 0x11, 0x22, 0x33 on consecutive cycles → out_valid rises 2 cycles after the first acceptance edge, with data 0x11, 0x22, 0x33 on consecutive cycles.
- Backpressure and collapse: DEPTH=3, out_ready=0, inject A, bubble, B, C → occupancy reaches 3 and in_ready=0. Raise out_ready → A, B, C exit in order with no gaps.
- Full plus simultaneous transfer: chain full, out_ready=1, in_valid=1 with 0xD → occupancy stays 3, in_ready=1, and 0xD is output 3 transfers later.
- Flush: DEPTH=2, full, flush=1 with in_valid=1 (0xEE) → next cycle stage_valid=0, occupancy=0, and 0xEE never appears at the output.
- DEPTH=1: in_valid=1 with 0xAB and out_ready=0 → out_valid=1 and in_ready=0 in the next cycle. Raise out_ready while in_valid=1 with 0xCD → 0xCD follows 0xAB back-to-back.
